mm_stream_fifo_source: RTL and testbench

Parametrised Avalon-MM slave to Avalon-ST source bridge with an internal FIFO. The processor writes words through the MM slave; the block buffers them and streams them out under the ST ready/valid handshake. Back-pressure is returned to the MM master through `avs_s0_waitrequest` when the FIFO is full. An optional packet mode adds start/end-of-packet framing. The block sits between a Nios/HPS data master and downstream streaming IP.

---
 rtl/mm_stream_fifo_source_if.sv | 41 ++++
 rtl/mm_stream_fifo_source.sv | 109 ++++++++++
 tb/tb_mm_stream_fifo_source.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_stream_fifo_source_if.sv
// Avalon-MM slave + Avalon-ST source signal bundle for mm_stream_fifo_source.
// SOP/EOP exist only when MM_ST_SRC_PKT_EN is defined.
interface mm_stream_fifo_source_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        avs_s0_address;
    logic [DATA_W-1:0] avs_s0_writedata;
    logic              avs_s0_write;
    logic              avs_s0_read;
    logic [31:0]       avs_s0_readdata;
    logic              avs_s0_waitrequest;
    logic [DATA_W-1:0] aso_out0_data;
    logic              aso_out0_valid;
    logic              aso_out0_ready;
`ifdef MM_ST_SRC_PKT_EN
    logic              aso_out0_startofpacket;
    logic              aso_out0_endofpacket;

    modport master (
        output avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read, aso_out0_ready,
        input  avs_s0_readdata, avs_s0_waitrequest, aso_out0_data, aso_out0_valid,
        input  aso_out0_startofpacket, aso_out0_endofpacket
    );

    modport slave (
        input  avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read, aso_out0_ready,
        output avs_s0_readdata, avs_s0_waitrequest, aso_out0_data, aso_out0_valid,
        output aso_out0_startofpacket, aso_out0_endofpacket
    );
`else
    modport master (
        output avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read, aso_out0_ready,
        input  avs_s0_readdata, avs_s0_waitrequest, aso_out0_data, aso_out0_valid
    );

    modport slave (
        input  avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read, aso_out0_ready,
        output avs_s0_readdata, avs_s0_waitrequest, aso_out0_data, aso_out0_valid
    );
`endif
endinterface

// File: rtl/mm_stream_fifo_source.sv
// Avalon-MM slave to Avalon-ST source bridge with a show-ahead FIFO.
// Define MM_ST_SRC_PKT_EN to store an eop bit per word and drive SOP/EOP framing.
module mm_stream_fifo_source #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset_n,
    mm_stream_fifo_source_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef MM_ST_SRC_PKT_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [LVL_W-1:0]   lvl;
    logic               overflow_sticky;
    logic               full;
    logic               data_addr;
    logic               push;
    logic               pop;
    logic               status_rd;
    logic [ENTRY_W-1:0] wr_entry;

    // Stall depends only on level and the write strobe, never on ready.
    assign full                   = (lvl == LVL_W'(DEPTH));
    assign data_addr              = (bus.avs_s0_address == 2'd0) || (bus.avs_s0_address == 2'd2);
    assign bus.avs_s0_waitrequest = full && bus.avs_s0_write;
    assign push                   = bus.avs_s0_write && !bus.avs_s0_waitrequest && data_addr;
    assign pop                    = bus.aso_out0_valid && bus.aso_out0_ready;
    assign status_rd              = bus.avs_s0_read && (bus.avs_s0_address == 2'd1);

    assign bus.aso_out0_valid = (lvl != '0);
    assign bus.aso_out0_data  = bus.aso_out0_valid ? mem[rd_ptr][DATA_W-1:0] : '0;

`ifdef MM_ST_SRC_PKT_EN
    assign wr_entry = {(bus.avs_s0_address == 2'd2), bus.avs_s0_writedata};
`else
    assign wr_entry = bus.avs_s0_writedata;
`endif

    // Storage is not reset; the output mux above hides stale contents.
    always_ff @(posedge csi_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + LVL_W'(1);
                2'b01:   lvl <= lvl - LVL_W'(1);
                default: lvl <= lvl;
            endcase
        end
    end

    // A new overflow in the same cycle as a STATUS read must not be lost.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            bus.avs_s0_readdata <= '0;
            overflow_sticky     <= 1'b0;
        end else begin
            bus.avs_s0_readdata <= status_rd ? {overflow_sticky, 15'b0, 16'(lvl)} : 32'b0;
            if (full && bus.avs_s0_write && data_addr) begin
                overflow_sticky <= 1'b1;
            end else if (status_rd) begin
                overflow_sticky <= 1'b0;
            end
        end
    end

`ifdef MM_ST_SRC_PKT_EN
    logic sop_pending;
    logic head_eop;

    assign head_eop = mem[rd_ptr][DATA_W];

    // The word after an eop word starts a new packet.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            sop_pending <= 1'b1;
        end else if (pop) begin
            sop_pending <= head_eop;
        end
    end

    assign bus.aso_out0_startofpacket = sop_pending && bus.aso_out0_valid;
    assign bus.aso_out0_endofpacket   = head_eop && bus.aso_out0_valid;
`endif

endmodule

// File: tb/tb_mm_stream_fifo_source.sv
// Self-checking bench for mm_stream_fifo_source: directed vectors plus a scoreboard monitor.
// Packet framing checks are built only when MM_ST_SRC_PKT_EN is defined.
module tb_mm_stream_fifo_source;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int N_RAND = 10000;

    logic csi_clk     = 1'b0;
    logic rsi_reset_n = 1'b0;

    mm_stream_fifo_source_if #(.DATA_W(DATA_W)) bus ();

    mm_stream_fifo_source #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .csi_clk    (csi_clk),
        .rsi_reset_n(rsi_reset_n),
        .bus        (bus)
    );

    always #5 csi_clk = ~csi_clk;

    int          assert_count = 0;
    int          fail_count   = 0;
    logic [31:0] exp_q [$];
    bit          mon_en    = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    int          mlvl;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] addr,
                                 input logic [31:0] wdata, input logic rdy);
        bus.avs_s0_write     = wr;
        bus.avs_s0_read      = rd;
        bus.avs_s0_address   = addr;
        bus.avs_s0_writedata = wdata;
        bus.aso_out0_ready   = rdy;
    endtask

    task automatic nextCycle();
        @(posedge csi_clk);
        #1;
    endtask

    // Wait (bounded) until the presented write is no longer stalled, then let it be taken.
    task automatic waitAccept(input string tag);
        int n = 0;
        @(negedge csi_clk);
        while (bus.avs_s0_waitrequest && n < 50) begin
            @(negedge csi_clk);
            n++;
        end
        checkOutput(tag, 32'(bus.avs_s0_waitrequest), 32'd0);
        nextCycle();
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        @(negedge csi_clk);
        while (bus.aso_out0_valid && n < 4 * DEPTH) begin
            @(negedge csi_clk);
            n++;
        end
        checkOutput(tag, 32'(bus.aso_out0_valid), 32'd0);
    endtask

    // Scoreboard: the model level is the number of words the bench expects to be buffered.
    always @(negedge csi_clk) begin
        if (!rsi_reset_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else if (mon_en) begin
            mlvl = exp_q.size();
            checkOutput("mon_valid", 32'(bus.aso_out0_valid), 32'(mlvl != 0));
            checkOutput("mon_waitreq", 32'(bus.avs_s0_waitrequest),
                        32'((mlvl == DEPTH) && bus.avs_s0_write));
            if (prev_hold) begin
                checkOutput("mon_hold", bus.aso_out0_data, prev_data);
            end
            if (mlvl != 0 && bus.aso_out0_ready) begin
                checkOutput("mon_data", bus.aso_out0_data, exp_q.pop_front());
            end
            if (bus.avs_s0_write && mlvl != DEPTH && (bus.avs_s0_address inside {2'd0, 2'd2})) begin
                exp_q.push_back(bus.avs_s0_writedata);
            end
            prev_hold = (mlvl != 0) && !bus.aso_out0_ready;
            prev_data = bus.aso_out0_data;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          tp_stalls;
        int          accepted;
        int          cycles;
        bit          held;
        int          r;
        logic [1:0]  addr;
        logic        rdy;

        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        rsi_reset_n = 1'b0;
        repeat (3) @(posedge csi_clk);
        @(negedge csi_clk);
        checkOutput("rst_valid", 32'(bus.aso_out0_valid), 32'd0);
        checkOutput("rst_data", bus.aso_out0_data, 32'd0);
        checkOutput("rst_waitreq", 32'(bus.avs_s0_waitrequest), 32'd0);
        checkOutput("rst_readdata", bus.avs_s0_readdata, 32'd0);
        #2;
        rsi_reset_n = 1'b1;
        mon_en      = 1'b1;

        // Single write, ready high: visible one cycle later, popped on the next edge.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 1'b1);
        @(negedge csi_clk);
        checkOutput("sw_waitreq", 32'(bus.avs_s0_waitrequest), 32'd0);
        checkOutput("sw_valid_before", 32'(bus.aso_out0_valid), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        @(negedge csi_clk);
        checkOutput("sw_valid", 32'(bus.aso_out0_valid), 32'd1);
        checkOutput("sw_data", bus.aso_out0_data, 32'hDEADBEEF);
        nextCycle();
        @(negedge csi_clk);
        checkOutput("sw_valid_after", 32'(bus.aso_out0_valid), 32'd0);

        // Writes to STATUS and the unused address are accepted but store nothing.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h11111111, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h33333333, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        @(negedge csi_clk);
        checkOutput("ign_valid", 32'(bus.aso_out0_valid), 32'd0);

        // Fill with ready low, ninth write stalls.
        for (int i = 1; i <= DEPTH; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 2'd0, 32'(i), 1'b0);
            @(negedge csi_clk);
            checkOutput("fill_waitreq", 32'(bus.avs_s0_waitrequest), 32'd0);
        end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd9, 1'b0);
        @(negedge csi_clk);
        checkOutput("full_waitreq", 32'(bus.avs_s0_waitrequest), 32'd1);
        checkOutput("full_head", bus.aso_out0_data, 32'd1);
        nextCycle();
        @(negedge csi_clk);
        checkOutput("full_waitreq_hold", 32'(bus.avs_s0_waitrequest), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd0, 1'b0);
        @(negedge csi_clk);
        checkOutput("status_full_ovf", bus.avs_s0_readdata, 32'h8000_0008);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
        @(negedge csi_clk);
        checkOutput("status_ovf_cleared", bus.avs_s0_readdata, 32'h0000_0008);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        @(negedge csi_clk);
        checkOutput("read_addr0", bus.avs_s0_readdata, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd9, 1'b1);
        waitAccept("fill_9th_accept");
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        waitDrain("fill_drain");

        // Back-to-back writes with ready high: no stalls, one-cycle latency.
        tp_stalls = 0;
        for (int i = 0; i < 100; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, (i % 2 == 1) ? 2'd2 : 2'd0, 32'h1000 + 32'(i), 1'b1);
            @(negedge csi_clk);
            if (bus.avs_s0_waitrequest) tp_stalls++;
            if (i > 0) checkOutput("tp_latency", bus.aso_out0_data, 32'h1000 + 32'(i - 1));
        end
        checkOutput("tp_stalls", 32'(tp_stalls), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        @(negedge csi_clk);
        checkOutput("tp_last", bus.aso_out0_data, 32'h1000 + 32'd99);
        nextCycle();
        @(negedge csi_clk);
        checkOutput("tp_empty", 32'(bus.aso_out0_valid), 32'd0);

        // Random writes and random ready; stalled writes are held until accepted.
        accepted = 0;
        cycles   = 0;
        held     = 1'b0;
        while (accepted < N_RAND && cycles < 60000) begin
            nextCycle();
            rdy = 1'($urandom_range(0, 1));
            if (held) begin
                bus.aso_out0_ready = rdy;
            end else if ($urandom_range(0, 3) != 0) begin
                r    = $urandom_range(0, 7);
                addr = (r == 0) ? 2'd1 : (r == 1) ? 2'd3 : ((r % 2 == 1) ? 2'd2 : 2'd0);
                applyStimulus(1'b1, 1'b0, addr, $urandom(), rdy);
            end else begin
                applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, rdy);
            end
            @(negedge csi_clk);
            held = bus.avs_s0_write && bus.avs_s0_waitrequest;
            if (bus.avs_s0_write && !bus.avs_s0_waitrequest && (bus.avs_s0_address inside {2'd0, 2'd2}))
                accepted++;
            cycles++;
        end
        checkOutput("rand_accepted", 32'(accepted), 32'(N_RAND));
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        waitDrain("rand_drain");

        // Asynchronous reset with words buffered flushes everything.
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 2'd0, 32'hA0 + 32'(i), 1'b0);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        @(negedge csi_clk);
        checkOutput("mid_valid_before", 32'(bus.aso_out0_valid), 32'd1);
        @(posedge csi_clk);
        #3;
        rsi_reset_n = 1'b0;
        #1;
        checkOutput("mid_valid_async", 32'(bus.aso_out0_valid), 32'd0);
        checkOutput("mid_data_async", bus.aso_out0_data, 32'd0);
        repeat (2) @(negedge csi_clk);
        #2;
        rsi_reset_n = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        @(negedge csi_clk);
        checkOutput("mid_status", bus.avs_s0_readdata, 32'd0);
        repeat (3) nextCycle();
        @(negedge csi_clk);
        checkOutput("mid_no_emit", 32'(bus.aso_out0_valid), 32'd0);

`ifdef MM_ST_SRC_PKT_EN
        begin
            logic [31:0] pkt_data [4];
            logic [1:0]  pkt_addr [4];
            logic        pkt_sop  [4];
            logic        pkt_eop  [4];
            pkt_data = '{32'hA, 32'hB, 32'hC, 32'hD};
            pkt_addr = '{2'd0, 2'd0, 2'd2, 2'd2};
            pkt_sop  = '{1'b1, 1'b0, 1'b0, 1'b1};
            pkt_eop  = '{1'b0, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 4; i++) begin
                nextCycle();
                applyStimulus(1'b1, 1'b0, pkt_addr[i], pkt_data[i], 1'b0);
            end
            nextCycle();
            applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
            for (int i = 0; i < 4; i++) begin
                @(negedge csi_clk);
                checkOutput("pkt_data", bus.aso_out0_data, pkt_data[i]);
                checkOutput("pkt_sop", 32'(bus.aso_out0_startofpacket), 32'(pkt_sop[i]));
                checkOutput("pkt_eop", 32'(bus.aso_out0_endofpacket), 32'(pkt_eop[i]));
                nextCycle();
            end
            @(negedge csi_clk);
            checkOutput("pkt_empty", 32'(bus.aso_out0_valid), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
